// File: rtl/pix_seq_pkg.sv
// Shared encodings and defaults for the picture sequencer.
// Optional reverse stepping is enabled by defining PIX_SEQ_REVERSE_EN.
package pix_seq_pkg;

    typedef enum logic {
        MODE_AUTO   = 1'b0,
        MODE_MANUAL = 1'b1
    } mode_e;

    // Debouncer: released waits for a stable low, held waits for a stable high.
    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_HELD     = 1'b1
    } key_state_e;

    localparam int unsigned DEF_PIX_NUM      = 11;
    localparam int unsigned DEF_PIX_W        = 4;
    localparam int unsigned DEF_DWELL_FRAMES = 300;
    localparam int unsigned DEF_DEB_CYCLES   = 1485000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_seq_if.sv
// Picture sequencer frame/key/picture bus.
// key_prev exists only when PIX_SEQ_REVERSE_EN is defined.
interface pix_seq_if import pix_seq_pkg::*; #(
    parameter int unsigned PIX_W = DEF_PIX_W
) ();

    logic             vsync;
    logic             key_mode;
    logic             key_next;
`ifdef PIX_SEQ_REVERSE_EN
    logic             key_prev;
`endif
    logic [PIX_W-1:0] pix_num;
    logic             pix_update;
    logic             mode;

    // Driver of frame sync and buttons, consumer of the picture index.
    modport master (
        output vsync, key_mode, key_next,
`ifdef PIX_SEQ_REVERSE_EN
        output key_prev,
`endif
        input  pix_num, pix_update, mode
    );

    // The sequencer itself.
    modport slave (
        input  vsync, key_mode, key_next,
`ifdef PIX_SEQ_REVERSE_EN
        input  key_prev,
`endif
        output pix_num, pix_update, mode
    );

endinterface

// File: rtl/key_filter.sv
// Button debouncer: one registered press pulse per stable press.
// A press needs DEB_CYCLES consecutive low samples; re-arming needs
// DEB_CYCLES consecutive high samples. Any bounce restarts the count.
module key_filter import pix_seq_pkg::*; #(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_press
);

    localparam int unsigned        CNT_W    = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // State, stability counter and press pulse registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= KEY_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Count consecutive samples at the level awaited by the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            KEY_RELEASED: begin
                if (key_in) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KEY_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KEY_HELD: begin
                if (!key_in) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KEY_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign key_press = press_q;

endmodule

// File: rtl/pix_sequencer.sv
// Picture rotation sequencer: auto dwell per picture or manual stepping,
// with pix_num changing only on a frame tick so the display never tears.
// Define PIX_SEQ_REVERSE_EN to add the key_prev backward-step button.
module pix_sequencer import pix_seq_pkg::*; #(
    parameter int unsigned PIX_NUM      = DEF_PIX_NUM,
    parameter int unsigned PIX_W        = DEF_PIX_W,
    parameter int unsigned DWELL_FRAMES = DEF_DWELL_FRAMES,
    parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES
) (
    input logic        vga_clk,
    input logic        sys_rst_n,
    pix_seq_if.slave   bus
);

    localparam int unsigned        FRAME_W    = cnt_width(DWELL_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(DWELL_FRAMES - 1);
    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIX_NUM - 1);

    logic               vsync_q;
    logic               frame_tick;
    logic               mode_press;
    logic               next_press;
    mode_e              mode_q, mode_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               pend_fwd_q, pend_fwd_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               upd_q, upd_d;
    logic               step_fwd;
`ifdef PIX_SEQ_REVERSE_EN
    logic               prev_press;
    logic               pend_rev_q, pend_rev_d;
    logic               step_rev;
`endif

    key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (bus.key_mode),
        .key_press (mode_press)
    );

    key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_next (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (bus.key_next),
        .key_press (next_press)
    );

`ifdef PIX_SEQ_REVERSE_EN
    key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_prev (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (bus.key_prev),
        .key_press (prev_press)
    );
`endif

    // Rising edge of vsync marks the start of a frame.
    assign frame_tick = bus.vsync & ~vsync_q;

    // Sequencer state registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_q     <= 1'b0;
            mode_q      <= MODE_AUTO;
            frame_cnt_q <= '0;
            pend_fwd_q  <= 1'b0;
            pix_q       <= '0;
            upd_q       <= 1'b0;
`ifdef PIX_SEQ_REVERSE_EN
            pend_rev_q  <= 1'b0;
`endif
        end else begin
            vsync_q     <= bus.vsync;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            pend_fwd_q  <= pend_fwd_d;
            pix_q       <= pix_d;
            upd_q       <= upd_d;
`ifdef PIX_SEQ_REVERSE_EN
            pend_rev_q  <= pend_rev_d;
`endif
        end
    end

    // Mode FSM, dwell counter, pending steps and picture index.
    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        pend_fwd_d  = pend_fwd_q;
        pix_d       = pix_q;
        step_fwd    = 1'b0;
`ifdef PIX_SEQ_REVERSE_EN
        pend_rev_d  = pend_rev_q;
        step_rev    = 1'b0;
`endif
        if (mode_press) begin
            // A toggle wins over a coinciding tick: no advance this frame.
            mode_d      = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
            frame_cnt_d = '0;
            pend_fwd_d  = 1'b0;
`ifdef PIX_SEQ_REVERSE_EN
            pend_rev_d  = 1'b0;
`endif
        end else if (mode_q == MODE_AUTO) begin
            if (frame_tick) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d = '0;
                    step_fwd    = 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end else begin
            frame_cnt_d = '0;
            if (frame_tick) begin
                // A press landing on the tick itself is kept for the next tick.
`ifdef PIX_SEQ_REVERSE_EN
                step_fwd   = pend_fwd_q & ~pend_rev_q;
                step_rev   = pend_rev_q & ~pend_fwd_q;
                pend_rev_d = prev_press;
`else
                step_fwd   = pend_fwd_q;
`endif
                pend_fwd_d = next_press;
            end else begin
                pend_fwd_d = pend_fwd_q | next_press;
`ifdef PIX_SEQ_REVERSE_EN
                pend_rev_d = pend_rev_q | prev_press;
`endif
            end
        end

        if (step_fwd) begin
            pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
        end
`ifdef PIX_SEQ_REVERSE_EN
        if (step_rev) begin
            pix_d = (pix_q == '0) ? PIX_LAST : pix_q - 1'b1;
        end
        upd_d = step_fwd | step_rev;
`else
        upd_d = step_fwd;
`endif
    end

    assign bus.pix_num    = pix_q;
    assign bus.pix_update = upd_q;
    assign bus.mode       = mode_q;

endmodule
